// File: rtl/if_fetch_unit_pkg.sv
// Shared definitions for the instruction-fetch front end: FSM state encoding and default widths.
package if_fetch_unit_pkg;

  localparam int DEF_PC_W   = 4;
  localparam int DEF_DATA_W = 32;

  typedef enum logic {
    S_FETCH = 1'b0,
    S_DROP  = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/if_fetch_unit_fetch_buf.sv
// Circular prefetch buffer: one write port at the tail, two read ports at head and head+1,
// occupancy count and a synchronous flush that empties the buffer without touching stored words.
module fetch_buf #(
  parameter int DATA_W    = 32,
  parameter int BUF_DEPTH = 4,
  localparam int PTR_W    = $clog2(BUF_DEPTH),
  localparam int CNT_W    = PTR_W + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data0,
  output logic [DATA_W-1:0] rd_data1,
  output logic [CNT_W-1:0]  count
);

  logic [DATA_W-1:0] mem [BUF_DEPTH];
  logic [PTR_W-1:0]  head;
  logic [PTR_W-1:0]  head_nx;
  logic [PTR_W-1:0]  tail;

  assign head_nx  = head + PTR_W'(1);
  assign tail     = head + count[PTR_W-1:0];
  assign rd_data0 = mem[head];
  assign rd_data1 = mem[head_nx];

  always_ff @(posedge clk) begin
    if (rst) begin
      head  <= '0;
      count <= '0;
      // NOTE: the storage is cleared on reset on purpose, because the instruction outputs
      // read straight from it and must show zero after reset.
      for (int i = 0; i < BUF_DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      count <= '0;
    end else begin
      if (wr_en) mem[tail] <= wr_data;
      if (rd_en) head <= head_nx;
      count <= count + CNT_W'(wr_en) - CNT_W'(rd_en);
    end
  end

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch front end feeding the IF/ID register with {instr, next instr, next PC}.
// Optional FETCH_STALL_CNT_EN adds a saturating count of cycles stalled with a valid pair.
module if_fetch_unit
  import if_fetch_unit_pkg::*;
#(
  parameter int              PC_W      = DEF_PC_W,
  parameter int              DATA_W    = DEF_DATA_W,
  parameter int              BUF_DEPTH = 4,
  parameter logic [PC_W-1:0] RESET_PC  = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              iRedirect,
  input  logic [PC_W-1:0]   iRedirectPC,
  output logic              imem_req,
  output logic [PC_W-1:0]   imem_addr,
  input  logic              imem_ack,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic              oValid,
  output logic [DATA_W-1:0] oInstr,
  output logic [DATA_W-1:0] oNextInstr,
  output logic [PC_W-1:0]   oNextPC
`ifdef FETCH_STALL_CNT_EN
  ,
  output logic [15:0]       oStallCnt
`endif
);

  localparam int CNT_W = $clog2(BUF_DEPTH) + 1;

  fetch_state_e     state;
  logic [PC_W-1:0]  head_pc;
  logic [PC_W-1:0]  fetch_pc;
  logic             pending;
  logic [CNT_W-1:0] count;
  logic             accept;
  logic             consume;

  // The request is held until acked, so the pending request is the one being presented and
  // only needs room for its own word.
  assign imem_req  = !rst && (state == S_FETCH) && !iRedirect && (count < CNT_W'(BUF_DEPTH));
  assign imem_addr = fetch_pc;
  assign accept    = imem_req && imem_ack;
  assign oValid    = (count >= CNT_W'(2)) && !iRedirect;
  assign consume   = oValid && enable;
  assign oNextPC   = head_pc + PC_W'(1);

  fetch_buf #(
    .DATA_W    (DATA_W),
    .BUF_DEPTH (BUF_DEPTH)
  ) u_buf (
    .clk      (clk),
    .rst      (rst),
    .flush    (iRedirect),
    .wr_en    (accept),
    .wr_data  (imem_rdata),
    .rd_en    (consume),
    .rd_data0 (oInstr),
    .rd_data1 (oNextInstr),
    .count    (count)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_FETCH;
      head_pc  <= RESET_PC;
      fetch_pc <= RESET_PC;
      pending  <= 1'b0;
    end else if (iRedirect) begin
      head_pc  <= iRedirectPC;
      fetch_pc <= iRedirectPC;
      pending  <= 1'b0;
      // A response landing in the redirect cycle is the one we would otherwise wait for.
      if (state == S_DROP) state <= imem_ack ? S_FETCH : S_DROP;
      else                 state <= (pending && !imem_ack) ? S_DROP : S_FETCH;
    end else begin
      case (state)
        S_FETCH: begin
          if (accept) fetch_pc <= fetch_pc + PC_W'(1);
          pending <= imem_req && !imem_ack;
        end
        S_DROP: begin
          if (imem_ack) state <= S_FETCH;
        end
        default: state <= S_FETCH;
      endcase
      if (consume) head_pc <= head_pc + PC_W'(1);
    end
  end

`ifdef FETCH_STALL_CNT_EN
  always_ff @(posedge clk) begin
    if (rst)                                         oStallCnt <= '0;
    else if (oValid && !enable && oStallCnt != '1)   oStallCnt <= oStallCnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// Self-checking bench for if_fetch_unit: directed vector table, hand-written corner sequences
// and randomized traffic against a queue-based reference model.
module tb_if_fetch_unit;

  localparam int PC_W   = 4;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 4;
  localparam int PC_MOD = 1 << PC_W;

  logic              clk = 1'b0;
  logic              rst, enable, iRedirect, force_ack;
  logic [PC_W-1:0]   iRedirectPC;
  logic              imem_req, imem_ack, oValid;
  logic [PC_W-1:0]   imem_addr, oNextPC;
  logic [DATA_W-1:0] imem_rdata, oInstr, oNextInstr;
`ifdef FETCH_STALL_CNT_EN
  logic [15:0]       oStallCnt, w_stall;
`endif

  logic              w_req, w_valid;
  logic [PC_W-1:0]   w_addr, w_npc;
  logic [DATA_W-1:0] w_instr, w_next;

  always #5 clk = ~clk;

  if_fetch_unit #(.PC_W(PC_W), .DATA_W(DATA_W), .BUF_DEPTH(DEPTH), .RESET_PC(4'd0)) dut (
    .clk(clk), .rst(rst), .enable(enable), .iRedirect(iRedirect), .iRedirectPC(iRedirectPC),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .oValid(oValid), .oInstr(oInstr), .oNextInstr(oNextInstr), .oNextPC(oNextPC)
`ifdef FETCH_STALL_CNT_EN
    , .oStallCnt(oStallCnt)
`endif
  );

  // Second instance starting near the top of the address space, zero-wait memory, always enabled.
  if_fetch_unit #(.PC_W(PC_W), .DATA_W(DATA_W), .BUF_DEPTH(DEPTH), .RESET_PC(4'd14)) dut_w (
    .clk(clk), .rst(rst), .enable(1'b1), .iRedirect(1'b0), .iRedirectPC(4'd0),
    .imem_req(w_req), .imem_addr(w_addr), .imem_ack(w_req), .imem_rdata(DATA_W'(w_addr)),
    .oValid(w_valid), .oInstr(w_instr), .oNextInstr(w_next), .oNextPC(w_npc)
`ifdef FETCH_STALL_CNT_EN
    , .oStallCnt(w_stall)
`endif
  );

  // Instruction memory holding mem[a] = a, with a programmable response latency.
  int              mem_lat = 0;
  logic            mem_busy = 1'b0;
  int              mem_rem = 0;
  logic [PC_W-1:0] mem_laddr = '0;

  always_comb begin
    imem_ack   = force_ack;
    imem_rdata = DATA_W'(imem_addr);
    if (mem_busy) begin
      imem_ack   = force_ack || (mem_rem == 0);
      imem_rdata = DATA_W'(mem_laddr);
    end else if (imem_req && mem_lat == 0) begin
      imem_ack = 1'b1;
    end
  end

  always @(posedge clk) begin
    if (mem_busy) begin
      if (mem_rem == 0) mem_busy <= 1'b0;
      else              mem_rem  <= mem_rem - 1;
    end else if (imem_req && mem_lat > 0) begin
      mem_busy  <= 1'b1;
      mem_rem   <= mem_lat - 1;
      mem_laddr <= imem_addr;
    end
  end

  // Reference model: the buffer is a queue of fetched words, PCs are plain integers mod 2^PC_W.
  int q[$];
  int m_head, m_fetch, m_stall;
  bit m_drop, m_pend;
  bit s_req, s_valid, s_ack, s_en, s_redir, s_rst;
  int s_rpc;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_head  = 0;
    m_fetch = 0;
    m_drop  = 1'b0;
    m_pend  = 1'b0;
    m_stall = 0;
  endtask

  // Compare the DUT against the model on the falling edge, latching what the model needs.
  task automatic sample();
    @(negedge clk);
    s_rst   = rst;
    s_en    = enable;
    s_redir = iRedirect;
    s_rpc   = int'(iRedirectPC);
    s_ack   = imem_ack;
    s_req   = !rst && !m_drop && !iRedirect && (q.size() < DEPTH);
    s_valid = (q.size() >= 2) && !iRedirect;
    check("req", imem_req, s_req);
    if (s_req) check("addr", imem_addr, m_fetch);
    check("valid", oValid, s_valid);
    check("next_pc", oNextPC, (m_head + 1) % PC_MOD);
    if (s_valid) begin
      check("instr", oInstr, q[0]);
      check("next_instr", oNextInstr, q[1]);
    end
`ifdef FETCH_STALL_CNT_EN
    check("stall_cnt", oStallCnt, m_stall);
`endif
  endtask

  task automatic advance();
    @(posedge clk);
    if (s_rst) begin
      model_reset();
    end else begin
      if (s_valid && !s_en && m_stall < 65535) m_stall++;
      if (s_redir) begin
        q.delete();
        m_head  = s_rpc;
        m_fetch = s_rpc;
        m_drop  = m_drop ? !s_ack : (m_pend && !s_ack);
        m_pend  = 1'b0;
      end else if (m_drop) begin
        if (s_ack) m_drop = 1'b0;
      end else begin
        if (s_valid && s_en) begin
          void'(q.pop_front());
          m_head = (m_head + 1) % PC_MOD;
        end
        if (s_req && s_ack) begin
          q.push_back(m_fetch);
          m_fetch = (m_fetch + 1) % PC_MOD;
        end
        m_pend = s_req && !s_ack;
      end
    end
    #1;
  endtask

  task automatic cycle();
    sample();
    advance();
  endtask

  typedef struct {
    logic en;
    logic req;   int addr;
    logic valid; int instr; int nxt; int npc;
    logic wchk;  int winstr; int wnxt; int wnpc;
  } vec_t;

  vec_t vec[11];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int  waited;
    bit  found;

    vec[0]  = '{1'b0, 1'b1, 0, 1'b0, 0, 0, 1, 1'b0, 0, 0, 0};
    vec[1]  = '{1'b0, 1'b1, 1, 1'b0, 0, 0, 1, 1'b0, 0, 0, 0};
    vec[2]  = '{1'b1, 1'b1, 2, 1'b1, 0, 1, 1, 1'b1, 14, 15, 15};
    vec[3]  = '{1'b0, 1'b1, 3, 1'b1, 1, 2, 2, 1'b1, 15, 0, 0};
    vec[4]  = '{1'b0, 1'b1, 4, 1'b1, 1, 2, 2, 1'b1, 0, 1, 1};
    vec[5]  = '{1'b0, 1'b0, 5, 1'b1, 1, 2, 2, 1'b0, 0, 0, 0};
    vec[6]  = '{1'b0, 1'b0, 5, 1'b1, 1, 2, 2, 1'b0, 0, 0, 0};
    vec[7]  = '{1'b0, 1'b0, 5, 1'b1, 1, 2, 2, 1'b0, 0, 0, 0};
    vec[8]  = '{1'b1, 1'b0, 5, 1'b1, 1, 2, 2, 1'b0, 0, 0, 0};
    vec[9]  = '{1'b1, 1'b1, 5, 1'b1, 2, 3, 3, 1'b0, 0, 0, 0};
    vec[10] = '{1'b1, 1'b1, 6, 1'b1, 3, 4, 4, 1'b0, 0, 0, 0};

    rst = 1'b1; enable = 1'b0; iRedirect = 1'b0; iRedirectPC = '0; force_ack = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;

    // Reset state.
    sample();
    check("rst_valid", oValid, 1'b0);
    check("rst_instr", oInstr, 32'd0);
    check("rst_next_instr", oNextInstr, 32'd0);
    check("rst_next_pc", oNextPC, 32'd1);
    check("rst_req", imem_req, 1'b0);
    advance();
    rst = 1'b0;

    // Start-up, stall with full buffer, release; wrap-around on the second instance.
    for (int i = 0; i < 11; i++) begin
      enable = vec[i].en;
      sample();
      check($sformatf("vec%0d_req", i), imem_req, vec[i].req);
      if (vec[i].req) check($sformatf("vec%0d_addr", i), imem_addr, vec[i].addr);
      check($sformatf("vec%0d_valid", i), oValid, vec[i].valid);
      check($sformatf("vec%0d_instr", i), oInstr, vec[i].instr);
      check($sformatf("vec%0d_next_instr", i), oNextInstr, vec[i].nxt);
      check($sformatf("vec%0d_next_pc", i), oNextPC, vec[i].npc);
      if (vec[i].wchk) begin
        check($sformatf("wrap%0d_valid", i), w_valid, 1'b1);
        check($sformatf("wrap%0d_instr", i), w_instr, vec[i].winstr);
        check($sformatf("wrap%0d_next_instr", i), w_next, vec[i].wnxt);
        check($sformatf("wrap%0d_next_pc", i), w_npc, vec[i].wnpc);
      end
      advance();
    end

    // Random traffic, zero-wait memory.
    for (int i = 0; i < 300; i++) begin
      enable      = ($urandom_range(0, 3) != 0);
      iRedirect   = ($urandom_range(0, 19) == 0);
      iRedirectPC = PC_W'($urandom_range(0, PC_MOD - 1));
      cycle();
    end
    iRedirect = 1'b0;
    enable    = 1'b1;
    repeat (3) cycle();

    // Redirect and ack in the same cycle: the word is dropped, no drop state.
    iRedirect = 1'b1; iRedirectPC = 4'd5; force_ack = 1'b1;
    cycle();
    iRedirect = 1'b0; force_ack = 1'b0;
    sample();
    check("same_cycle_req", imem_req, 1'b1);
    check("same_cycle_addr", imem_addr, 32'd5);
    advance();
    cycle();
    sample();
    check("same_cycle_valid", oValid, 1'b1);
    check("same_cycle_pair", {oInstr[15:0], oNextInstr[15:0]}, {16'd5, 16'd6});
    check("same_cycle_npc", oNextPC, 32'd6);
    advance();

    // Redirect to 9 with a 3-cycle request outstanding.
    rst = 1'b1;
    repeat (2) cycle();
    rst = 1'b0; mem_lat = 3;
    cycle();
    iRedirect = 1'b1; iRedirectPC = 4'd9;
    cycle();
    iRedirect = 1'b0;
    waited = 0; found = 1'b0;
    for (int i = 0; i < 10; i++) begin
      sample();
      if (imem_req) begin found = 1'b1; break; end
      waited++;
      advance();
    end
    check("drop_req_found", found, 1'b1);
    check("drop_wait_cycles", waited, 2);
    check("drop_first_addr", imem_addr, 32'd9);
    advance();
    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      sample();
      if (oValid) begin found = 1'b1; break; end
      advance();
    end
    check("drop_valid_found", found, 1'b1);
    check("drop_pair", {oInstr[15:0], oNextInstr[15:0]}, {16'd9, 16'd10});
    check("drop_npc", oNextPC, 32'd10);
    advance();

    // Random traffic, 2-cycle memory, including redirects over outstanding requests.
    mem_lat = 2;
    for (int i = 0; i < 300; i++) begin
      enable      = ($urandom_range(0, 3) != 0);
      iRedirect   = ($urandom_range(0, 11) == 0);
      iRedirectPC = PC_W'($urandom_range(0, PC_MOD - 1));
      cycle();
    end
    iRedirect = 1'b0;

    // Reset mid-stream with a request pending; the late ack arrives while req=0.
    mem_lat = 3;
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      sample();
      if (imem_req && mem_busy) begin found = 1'b1; break; end
      advance();
    end
    check("rst_pending_found", found, 1'b1);
    advance();
    rst = 1'b1;
    cycle();
    sample();
    check("rst_mid_valid", oValid, 1'b0);
    check("rst_mid_req", imem_req, 1'b0);
    advance();
    repeat (2) cycle();
    rst = 1'b0;
    sample();
    check("rst_refetch_addr", imem_addr, 32'd0);
    advance();
    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      sample();
      if (oValid) begin found = 1'b1; break; end
      advance();
    end
    check("rst_refetch_valid", found, 1'b1);
    check("rst_refetch_pair", {oInstr[15:0], oNextInstr[15:0]}, {16'd0, 16'd1});
    advance();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
